uart_rx_sipo: RTL and testbench

//  Serial-in/parallel-out UART receiver; downstream peer of the TX PISO stage on the serial line.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_sync.sv | 32 +++
 rtl/uart_rx_sipo.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx_sipo.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// Receiver FSM state encoding, fixed frame bit values and the
// 2-of-3 vote helper used when UART_RX_MAJORITY_VOTE_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic UART_STOP_BIT  = 1'b1;
  localparam logic UART_START_BIT = 1'b0;

  // 2-of-3 majority of three line samples
  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus a
// falling-edge detector on the synchronized value. All flops reset to
// the idle line level (1) so reset release never looks like a start edge.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_i,
  output logic rx_o,
  output logic fall_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Metastability chain plus one extra stage holding the previous synced value
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rx_o   = sync2_q;
  assign fall_o = prev_q & ~sync2_q;

endmodule

// File: rtl/uart_rx_sipo.sv
// Serial-in/parallel-out UART receiver.
// Frame: start(0), DATA_W data bits LSB first, optional parity, one stop(1).
// The line is oversampled OVERSAMPLE times per bit; every bit is taken at
// its mid-period, measured from the cycle the start edge is detected.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: each bit becomes the
// 2-of-3 majority of the samples at nominal-1, nominal and nominal+1, which
// moves every decision (and the output latency) one cycle later.
module uart_rx_sipo
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic              baud_clk,
  input  logic              rst_n,
  input  logic              data_rx,
  input  logic              parity_en,
  input  logic              parity_odd,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_error,
  output logic              stop_error,
  output logic              active_flag,
  output logic              done_flag
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_W + 1);

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int VOTE_DLY = 1;
`else
  localparam int VOTE_DLY = 0;
`endif

  // Start bit is judged half a bit after the edge; later bits one full bit apart
  localparam logic [TICK_W-1:0] START_TICK = TICK_W'(OVERSAMPLE / 2 - 1 + VOTE_DLY);
  localparam logic [TICK_W-1:0] BIT_TICK   = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT   = BIT_W'(DATA_W - 1);

  logic rx_s;
  logic rx_fall;
  logic samp_bit;
  logic samp_now;

  rx_state_t          state_q, state_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [BIT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic               pen_q, pen_d;
  logic               podd_q, podd_d;
  logic               par_bad_q, par_bad_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic               valid_q, valid_d;
  logic               perr_q, perr_d;
  logic               serr_q, serr_d;

  uart_rx_sync u_sync (
    .clk_i  (baud_clk),
    .rst_ni (rst_n),
    .rx_i   (data_rx),
    .rx_o   (rx_s),
    .fall_o (rx_fall)
  );

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] hist_q;

  // Keep the two previous synced samples so the vote can be taken at nominal+1
  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rx_s};
    end
  end

  assign samp_bit = maj3({hist_q, rx_s});
`else
  assign samp_bit = rx_s;
`endif

  // Decision point: tick count reached the mid-bit position for this state
  assign samp_now = (state_q == START) ? (tick_q == START_TICK) : (tick_q == BIT_TICK);

  // Next-state logic: frame sequencing, bit shifting and result capture
  always_comb begin
    state_d   = state_q;
    tick_d    = (tick_q == BIT_TICK) ? '0 : tick_q + 1'b1;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    pen_d     = pen_q;
    podd_d    = podd_q;
    par_bad_d = par_bad_q;
    dout_d    = dout_q;
    valid_d   = 1'b0;
    perr_d    = perr_q;
    serr_d    = serr_q;

    case (state_q)
      IDLE: begin
        tick_d = '0;
        if (rx_fall) begin
          // Parity configuration is frozen for the whole frame at the edge
          state_d   = START;
          bitcnt_d  = '0;
          pen_d     = parity_en;
          podd_d    = parity_odd;
          par_bad_d = 1'b0;
        end
      end

      START: begin
        if (samp_now) begin
          tick_d = '0;
          // A line that is high again at mid-start was only a glitch
          state_d = (samp_bit == UART_START_BIT) ? DATA : IDLE;
        end
      end

      DATA: begin
        if (samp_now) begin
          shreg_d  = {samp_bit, shreg_q[DATA_W-1:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == LAST_BIT) begin
            state_d = pen_q ? PARITY : STOP;
          end
        end
      end

      PARITY: begin
        if (samp_now) begin
          par_bad_d = ((^shreg_q) ^ samp_bit) != podd_q;
          state_d   = STOP;
        end
      end

      STOP: begin
        if (samp_now) begin
          // Back to IDLE at mid-stop so a frame can follow with one stop bit
          dout_d  = shreg_q;
          valid_d = 1'b1;
          perr_d  = pen_q & par_bad_q;
          serr_d  = (samp_bit != UART_STOP_BIT);
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and output registers; async reset aborts any frame in progress
  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bitcnt_q  <= '0;
      pen_q     <= 1'b0;
      podd_q    <= 1'b0;
      par_bad_q <= 1'b0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      serr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bitcnt_q  <= bitcnt_d;
      pen_q     <= pen_d;
      podd_q    <= podd_d;
      par_bad_q <= par_bad_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      serr_q    <= serr_d;
    end
  end

  // Payload shift register; its content only matters once a frame completes
  always_ff @(posedge baud_clk) begin
    shreg_q <= shreg_d;
  end

  assign data_out     = dout_q;
  assign data_valid   = valid_q;
  assign parity_error = perr_q;
  assign stop_error   = serr_q;
  assign active_flag  = (state_q != IDLE);
  assign done_flag    = (state_q == IDLE);

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Self-checking bench for uart_rx_sipo (DATA_W=8, OVERSAMPLE=16).
// Frames are driven bit by bit on data_rx; each frame pushes its expected
// word, error flags and valid cycle into a queue that a negedge monitor
// pops whenever data_valid is seen.
module tb_uart_rx_sipo;

  localparam int DW = 8;
  localparam int OS = 16;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int VD = 1;
`else
  localparam int VD = 0;
`endif

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic          data_rx    = 1'b1;
  logic          parity_en  = 1'b0;
  logic          parity_odd = 1'b0;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          parity_error;
  logic          stop_error;
  logic          active_flag;
  logic          done_flag;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       se;
    int         at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests   = 0;
  int   n_fail    = 0;
  int   n_valid   = 0;
  int   n_frames  = 0;
  int   last_vcyc = 0;
  int   prev_vcyc = 0;
  int   cyc       = 0;

  uart_rx_sipo #(.DATA_W(DW), .OVERSAMPLE(OS)) dut (
    .baud_clk     (clk),
    .rst_n        (rst_n),
    .data_rx      (data_rx),
    .parity_en    (parity_en),
    .parity_odd   (parity_odd),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .parity_error (parity_error),
    .stop_error   (stop_error),
    .active_flag  (active_flag),
    .done_flag    (done_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding frame
  always @(negedge clk) begin
    if (data_valid) begin
      n_valid++;
      prev_vcyc = last_vcyc;
      last_vcyc = cyc;
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("data_out", int'(data_out), int'(mon_e.d));
        check("parity_error", int'(parity_error), int'(mon_e.pe));
        check("stop_error", int'(stop_error), int'(mon_e.se));
        check("valid_cycle", cyc, mon_e.at);
      end
    end
  end

  // One bit period; optional one-cycle inversion at the nominal sample point
  task automatic send_bit(input logic v, input bit glitch);
    data_rx = v;
    repeat (8) @(negedge clk);
    if (glitch) data_rx = ~v;
    @(negedge clk);
    data_rx = v;
    repeat (7) @(negedge clk);
  endtask

  // Full frame; glitch_idx 0=start, 1..8 data bits, 9 parity, -1 none
  task automatic send_frame(input logic [7:0] d, input bit pen, input bit podd,
                            input bit pflip, input logic stopv, input int glitch_idx,
                            input int stop_cycles);
    exp_t e;
    logic pbit;
    int   c0;
    pbit = podd ? ~^d : ^d;
    if (pflip) pbit = ~pbit;
    parity_en  = pen;
    parity_odd = podd;
    c0   = cyc;
    e.d  = d;
    e.pe = pen & pflip;
    e.se = ~stopv;
    // 2 sync cycles to T0, then half bit + (DW+1+P) bits + 1 output cycle
    e.at = c0 + 2 + OS / 2 + (DW + 1 + (pen ? 1 : 0)) * OS + 1 + VD;
    sb.push_back(e);
    n_frames++;
    send_bit(1'b0, glitch_idx == 0);
    // Inputs change mid-frame; the latched values must be used
    parity_en  = ~pen;
    parity_odd = ~podd;
    for (int i = 0; i < DW; i++) send_bit(d[i], glitch_idx == i + 1);
    if (pen) send_bit(pbit, glitch_idx == 9);
    data_rx = stopv;
    repeat (stop_cycles) @(negedge clk);
    data_rx    = 1'b1;
    parity_en  = pen;
    parity_odd = podd;
  endtask

  initial begin
    int act_cnt;
    int vbefore;
    logic [7:0] rd;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data_out", int'(data_out), 0);
    check("rst_valid", int'(data_valid), 0);
    check("rst_active", int'(active_flag), 0);
    check("rst_done", int'(done_flag), 1);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_done", int'(done_flag), 1);
    check("idle_perr", int'(parity_error), 0);
    check("idle_serr", int'(stop_error), 0);

    // 1: 0xA5, even parity, good
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, -1, 16);
    repeat (20) @(negedge clk);

    // 2: 0x3C, even parity, parity bit inverted
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1, 16);
    repeat (20) @(negedge clk);
    check("perr_held", int'(parity_error), 1);
    check("data_held", int'(data_out), 8'h3C);

    // Odd parity, good: 0x07 has three ones
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b1, -1, 16);
    repeat (20) @(negedge clk);

    // 3: stop bit 0 with the line held low 40 cycles
    vbefore = n_valid;
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, -1, 40);
    repeat (60) @(negedge clk);
    check("break_single_valid", n_valid - vbefore, 1);
    check("serr_held", int'(stop_error), 1);
    check("break_idle", int'(done_flag), 1);

    // 4: 4-cycle low glitch on the idle line
    vbefore = n_valid;
    act_cnt = 0;
    data_rx = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 4) data_rx = 1'b1;
      @(negedge clk);
      if (active_flag) act_cnt++;
    end
    check("glitch_active_cycles", act_cnt, 8 + VD);
    check("glitch_no_valid", n_valid - vbefore, 0);
    check("glitch_done", int'(done_flag), 1);

    // 5: async reset during data bit 3
    rd = 8'hC3;
    parity_en = 1'b0;
    send_bit(1'b0, 1'b0);
    send_bit(rd[0], 1'b0);
    send_bit(rd[1], 1'b0);
    data_rx = rd[2];
    repeat (5) @(negedge clk);
    check("mid_frame_active", int'(active_flag), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_data_out", int'(data_out), 0);
    check("arst_serr", int'(stop_error), 0);
    check("arst_perr", int'(parity_error), 0);
    check("arst_valid", int'(data_valid), 0);
    check("arst_active", int'(active_flag), 0);
    check("arst_done", int'(done_flag), 1);
    data_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, -1, 16);
    repeat (20) @(negedge clk);

    // 6: back-to-back frames with exactly one stop bit
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, -1, 16);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, -1, 16);
    repeat (20) @(negedge clk);
    check("b2b_spacing", last_vcyc - prev_vcyc, 160);

`ifdef UART_RX_MAJORITY_VOTE_EN
    // One-cycle inversion at a data bit sample point is outvoted
    send_frame(8'h96, 1'b1, 1'b1, 1'b0, 1'b1, 4, 16);
    repeat (20) @(negedge clk);
`endif

    repeat (50) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    check("valid_count", n_valid, n_frames);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
